nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that time-shares one external 4-bit ripple adder (A,B,Cin -> S,Cout) to add or
//  subtract two 4*NIBBLES-bit operands, least significant nibble first, one nibble per clock.
//  It sits between the ALU operand/opcode registers and the shared adder instance. Handshake is
//  start/ready/done. It returns the wide result, the carry-out and the signed-overflow flag.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles (W = 4*NIBBLES bits); legal range 2..16
// PORTS
//  clk      in   1   single clock; all state changes on rising edge
//  rst      in   1   synchronous reset, active-high
//  start    in   1   request; sampled only when ready=1
//  sub      in   1   0: A+B, 1: A-B (two's complement); sampled with start
//  op_a     in   W   operand A; sampled with start
//  op_b     in   W   operand B; sampled with start
//  ready    out  1   1 in IDLE: a start will be accepted
//  busy     out  1   1 in RUN or DONE
//  add_a    out  4   to adder A: nibble idx of latched A
//  add_b    out  4   to adder B: nibble idx of latched B (already inverted if sub)
//  add_cin  out  1   to adder Cin: carry register
//  add_s    in   4   from adder S (combinational from add_a/add_b/add_cin)
//  add_cout in   1   from adder Cout
//  result   out  W   last completed result; holds until the next op completes
//  cout     out  1   carry out of MSB nibble (for sub: 1 = no borrow)
//  ovf      out  1   signed overflow of the last completed op
//  done     out  1   one-cycle pulse: result/cout/ovf just updated
// BEHAVIOUR
//  - Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, ovf=0, idx=0,
//    carry=0, add_a/add_b/add_cin=0.
//  - FSM IDLE -> RUN on start&ready. RUN -> DONE when idx==NIBBLES-1. DONE -> IDLE unconditionally.
//  - On accept: a_q<=op_a; b_q<=sub ? ~op_b : op_b; carry<=sub; idx<=0; acc<=0.
//  - RUN cycle: add_a=a_q[4*idx+:4], add_b=b_q[4*idx+:4], add_cin=carry; at edge
//    acc[4*idx+:4]<=add_s; carry<=add_cout; idx<=idx+1 (idx reaches NIBBLES-1, then does not wrap).
//  - Entering DONE: result<=acc with last nibble, cout<=final add_cout,
//    ovf<=(a_q[W-1]==b_q[W-1]) && (sum[W-1]!=a_q[W-1]), using inverted B for sub.
//  - done=(state==DONE): high exactly one cycle.
//  - Latency: start sampled at edge 0 -> done high between edges NIBBLES and NIBBLES+1.
//    ready returns after edge NIBBLES+1. Throughput is one op per NIBBLES+2 cycles.
//  - IDLE/DONE: add_a/add_b/add_cin driven 0. The adder output is ignored.
//  - start while busy (RUN or DONE) is ignored. It is not queued. Operands may change freely after accept.
//  - result/cout/ovf never show partial values. They change only on entry to DONE.
//  - rst mid-operation: the next cycle is IDLE with all reset values (result/cout/ovf cleared,
//    no done pulse). rst dominates start in the same cycle.
//  - Arithmetic is modulo 2^W. The carry chain is only through the carry register between nibbles.
// TESTING (NIBBLES=4, shared FourBitAdder instance in the loop)
//  1. add 0x1234+0x4321 -> result=0x5555, cout=0, ovf=0; done exactly 4 cycles after the start edge.
//  2. add 0xFFFF+0x0001 -> result=0x0000, cout=1, ovf=0. add 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1.
//  3. sub 0x0007-0x0005 -> 0x0002, cout=1. sub 0x0005-0x0007 -> 0xFFFE, cout=0.
//     sub 0x8000-0x0001 -> 0x7FFF, ovf=1.
//  4. start pulsed again in RUN and in DONE with other operands -> ignored; the first result is unchanged.
//     A new start on the first ready cycle is accepted.
//  5. rst asserted during the 2nd RUN cycle of 0x1234+0x4321 -> next cycle ready=1, result=0,
//     no done pulse. A following op runs normally.
//  6. rst and start asserted together -> start is ignored and state stays IDLE.
//     Random 1000-op compare against a W-bit reference model.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer driving one shared external 4-bit adder.
// Operands are latched on accept; one nibble per clock, LSB first.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 ready,
    output logic                 busy,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic                 done
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic run;

    assign run   = (state_q == S_RUN);
    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);

    // Adder inputs are forced to zero outside RUN so the shared adder sees no stale operands.
    assign add_a   = run ? a_q[4*idx_q +: 4] : 4'd0;
    assign add_b   = run ? b_q[4*idx_q +: 4] : 4'd0;
    assign add_cin = run ? carry_q : 1'b0;

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                acc_d[4*idx_q +: 4] = add_s;
                carry_d             = add_cout;
                if (idx_q == LAST) begin
                    state_d  = S_DONE;
                    result_d = acc_d;
                    cout_d   = add_cout;
                    // Sign of the sum is the top bit of the final nibble just produced.
                    ovf_d    = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: arithmetic reference model plus directed
// literal checks, with a combinational 4-bit adder closing the loop.
module tb_nibble_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         ready, busy, done, cout, ovf;
    logic [3:0]   add_a, add_b, add_s;
    logic         add_cin, add_cout;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b),
        .ready(ready), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .result(result), .cout(cout), .ovf(ovf), .done(done)
    );

    // Shared 4-bit adder in the loop
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    always #5 clk = ~clk;

    // Reference model: t = cycles since accept (-1 when idle)
    int          t = -1;
    logic [W-1:0] pa, pb;
    logic         ps;
    logic [W-1:0] er = '0;
    logic         ec = 1'b0, eo = 1'b0;
    int           nops = 0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        logic [W:0] full;
        int         ex;
        if (rst) begin
            t = -1; er = '0; ec = 1'b0; eo = 1'b0;
        end else if (t < 0) begin
            if (start) begin
                t = 0; pa = op_a; pb = op_b; ps = sub;
            end
        end else begin
            t++;
            if (t == N) begin
                if (ps) begin
                    full = {1'b0, pa} + {1'b0, ~pb} + 17'd1;
                    ex = int'($signed(pa)) - int'($signed(pb));
                end else begin
                    full = {1'b0, pa} + {1'b0, pb};
                    ex = int'($signed(pa)) + int'($signed(pb));
                end
                er = full[W-1:0];
                ec = full[W];
                eo = (ex > 32767) || (ex < -32768);
                nops++;
            end else if (t == N + 1) begin
                t = -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] ea, eb;
        logic       ecin;
        int         bb, lowm, part;
        if (chk_en) begin
            ea = 4'd0; eb = 4'd0; ecin = 1'b0;
            if (t >= 0 && t < N) begin
                bb   = ps ? int'(~pb) : int'(pb);
                lowm = (1 << (4 * t)) - 1;
                part = (int'(pa) & lowm) + (bb & lowm) + int'(ps);
                ea   = 4'((int'(pa) >> (4 * t)) & 15);
                eb   = 4'((bb >> (4 * t)) & 15);
                ecin = ((part >> (4 * t)) & 1) != 0;
            end
            tests++;
            if (ready !== (t < 0) || busy !== (t >= 0) || done !== (t == N)) begin
                fails++;
                $display("FAIL hs t=%0d: ready=%b busy=%b done=%b, required %b %b %b",
                         t, ready, busy, done, t < 0, t >= 0, t == N);
            end
            tests++;
            if (result !== er || cout !== ec || ovf !== eo) begin
                fails++;
                $display("FAIL flags t=%0d: result=%h cout=%b ovf=%b, required %h %b %b",
                         t, result, cout, ovf, er, ec, eo);
            end
            tests++;
            if (add_a !== ea || add_b !== eb || add_cin !== ecin) begin
                fails++;
                $display("FAIL adder t=%0d: a=%h b=%h cin=%b, required %h %h %b",
                         t, add_a, add_b, add_cin, ea, eb, ecin);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!done && n < 20);
        if (!done) check("done_timeout", 32'(n), 32'(N));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] xr, input logic xc, input logic xo);
        int n;
        start = 1'b1; op_a = a; op_b = b; sub = s;
        cyc();
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); sub = $urandom_range(0, 1) == 1;
        wait_done(n);
        check("latency", 32'(n), 32'(N));
        check("result", 32'(result), 32'(xr));
        check("cout", 32'(cout), 32'(xc));
        check("ovf", 32'(ovf), 32'(xo));
        cyc();
    endtask

    task automatic no_done_for(input int k, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < k; i++) begin
            cyc();
            if (done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int n;
        int target;
        int budget;
        @(negedge clk);
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // start held through RUN and DONE, then accepted on first ready cycle
        start = 1'b1; sub = 1'b0; op_a = 16'h1234; op_b = 16'h4321;
        cyc();
        op_a = 16'hAAAA; op_b = 16'h1111;
        wait_done(n);
        check("busy_start_lat", 32'(n), 32'(N));
        check("busy_start_res", 32'(result), 32'h5555);
        cyc();
        check("ready_after_done", 32'(ready), 32'd1);
        cyc();
        start = 1'b0;
        check("reaccept_busy", 32'(busy), 32'd1);
        wait_done(n);
        check("reaccept_res", 32'(result), 32'hBBBB);
        cyc();

        // rst in the 2nd RUN cycle
        start = 1'b1; sub = 1'b0; op_a = 16'h1234; op_b = 16'h4321;
        cyc();
        start = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_result", 32'(result), 32'd0);
        no_done_for(8, "midrst_nodone");
        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        // rst and start together
        rst = 1'b1; start = 1'b1; op_a = 16'h0F0F; op_b = 16'h0101;
        cyc();
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_ready", 32'(ready), 32'd1);
        no_done_for(8, "rst_start_nodone");

        // random traffic, including starts while busy and rare resets
        target = nops + 1000;
        budget = 0;
        while (nops < target && budget < 30000) begin
            start = $urandom_range(0, 3) != 0;
            sub   = $urandom_range(0, 1) == 1;
            op_a  = W'($urandom);
            op_b  = W'($urandom);
            rst   = $urandom_range(0, 199) == 0;
            cyc();
            budget++;
        end
        rst = 1'b0; start = 1'b0;
        check("random_ops_done", 32'(nops >= target), 32'd1);
        cyc(); cyc(); cyc();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
